// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the control unit:
// opcode/funct fields, the symbolic operation enum and the loader FSM states.
package mips_isa_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011100;

    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_SLT  = 4'd4,
        OP_MUL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_BEQ  = 4'd7,
        OP_J    = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Builds an R-type word; shamt is always zero for the supported subset.
    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

endpackage

// File: rtl/mips_inst_encoder_if.sv
// Instruction-field handshake and instruction-memory write port of the encoder.
// master: the field producer / memory side; slave: the encoder itself.
interface mips_inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [25:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_word_pack.sv
// Combinational packer: symbolic {op, rs, rt, rd, imm} -> 32-bit MIPS word.
// Unused fields are forced to zero; ops 9..15 flag o_illegal with a zero word.
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [25:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    // Select the encoding format from the symbolic operation.
    always_comb begin
        o_word    = 32'h0000_0000;
        o_illegal = 1'b0;
        case (i_op)
            OP_LW:   o_word = {OPC_LW,   i_rs, i_rt, i_imm[15:0]};
            OP_SW:   o_word = {OPC_SW,   i_rs, i_rt, i_imm[15:0]};
            OP_ADDI: o_word = {OPC_ADDI, i_rs, i_rt, i_imm[15:0]};
            OP_BEQ:  o_word = {OPC_BEQ,  i_rs, i_rt, i_imm[15:0]};
            OP_ADD:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_ADD);
            OP_SUB:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_SUB);
            OP_SLT:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_SLT);
            OP_MUL:  o_word = rtype_word(i_rs, i_rt, i_rd, FN_MUL);
            OP_J:    o_word = {OPC_J, i_imm};
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_inst_encoder.sv
// Program loader: accepts symbolic instructions over a valid/ready handshake,
// packs them into MIPS words and writes them sequentially to instruction memory.
// Optional build macro MIPS_ENC_CHECKSUM_EN adds an XOR checksum of written words.
module mips_inst_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    mips_inst_encoder_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     count,
    output logic [31:0]         chksum
);

    localparam int unsigned CAP = 1 << ADDR_W;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       r_word;
    logic              r_last;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic [ADDR_W+1:0] w_end;
    logic              w_full;

    mips_word_pack u_pack (
        .i_op      (bus.in_op),
        .i_rs      (bus.in_rs),
        .i_rt      (bus.in_rt),
        .i_rd      (bus.in_rd),
        .i_imm     (bus.in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // The word being written is the last one in memory when BASE+count+1 reaches capacity.
    assign w_end  = (ADDR_W+2)'(BASE_ADDR) + (ADDR_W+2)'(r_count) + (ADDR_W+2)'(1);
    assign w_full = (w_end == (ADDR_W+2)'(CAP));

    // State register; async reset drops the write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the load session.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
                else       w_state_nxt = S_IDLE;
            end
            S_LOAD: begin
                if (!bus.in_valid)     w_state_nxt = S_LOAD;
                else if (!w_illegal)   w_state_nxt = S_WRITE;
                else if (bus.in_last)  w_state_nxt = S_DONE;
                else                   w_state_nxt = S_LOAD;
            end
            S_WRITE: begin
                if (r_last || w_full) w_state_nxt = S_DONE;
                else                  w_state_nxt = S_LOAD;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Session datapath: captured word, write address, word count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_count <= '0;
            r_err   <= 1'b0;
            r_word  <= 32'h0000_0000;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= ADDR_W'(BASE_ADDR);
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            r_word <= w_word;
                            r_last <= bus.in_last;
                        end
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_count <= r_count + (ADDR_W+1)'(1);
                    if (!r_last && w_full) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_last <= r_last;
                end
            endcase
        end
    end

`ifdef MIPS_ENC_CHECKSUM_EN
    logic [31:0] r_chk;

    // Running XOR of every word written in the current session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk <= 32'h0000_0000;
        end else if (r_state == S_IDLE && start) begin
            r_chk <= 32'h0000_0000;
        end else if (r_state == S_WRITE) begin
            r_chk <= r_chk ^ r_word;
        end else begin
            r_chk <= r_chk;
        end
    end

    assign chksum = r_chk;
`else
    assign chksum = 32'h0000_0000;
`endif

    // Outputs decode directly from flops so they carry no combinational input paths.
    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_word;
    assign busy           = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done           = (r_state == S_DONE);
    assign err            = r_err;
    assign count          = r_count;

endmodule

// File: doc/mips_inst_encoder.md
Name: mips_inst_encoder

Overview:
- Encoder counterpart of the control-unit decoder: accepts symbolic instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words.
- Writes the packed words sequentially into instruction memory through a write port.
- Used as the program loader in front of the instruction memory during bring-up and testbench preload.
- Covers the ISA subset the datapath decodes: LW, SW, ADD, SUB, SLT, MUL, ADDI, BEQ, J.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load session; ignored unless the block is in IDLE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block accepts fields this cycle.
- in_op  in  4  0=LW 1=SW 2=ADD 3=SUB 4=SLT 5=MUL 6=ADDI 7=BEQ 8=J; 9-15 are illegal.
- in_rs  in  5  source register.
- in_rt  in  5  target register.
- in_rd  in  5  destination register (R-type only).
- in_imm  in  26  imm16 in [15:0], or J target in [25:0].
- in_last  in  1  marks the final instruction of the session.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction word.
- busy  out  1  session in progress (high in LOAD or WRITE).
- done  out  1  one-cycle pulse when a session ends.
- err  out  1  sticky error flag; cleared only by start or reset.
- count  out  ADDR_W+1  number of words written this session.
- chksum  out  32  running checksum (see Optional Feature).

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - The address register is BASE_ADDR.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - start -> LOAD.
  - On the same edge, clear count, err and chksum, and load the address register with BASE_ADDR.
- LOAD:
  - in_ready=1.
  - A handshake occurs when in_valid && in_ready.
  - Legal op: register the encoded word -> WRITE.
  - Illegal op: set err, write nothing, address unchanged; if in_last -> DONE, else stay in LOAD.
- WRITE:
  - in_ready=0.
  - imem_we=1 for exactly one cycle, with imem_addr and imem_wdata held stable.
  - At the end of the cycle: address+1, count+1.
  - If in_last was set -> DONE.
  - Else, if the address just written is the last memory word (BASE_ADDR+count+1 == 2**ADDR_W) -> set err, -> DONE.
  - Else -> LOAD.
- DONE: done=1 for one cycle -> IDLE.
- Latency: handshake at edge N; write strobe during cycle N+1. Maximum throughput is one word per 2 cycles.
- Encoding rules:
  - LW/SW/ADDI/BEQ: {opcode, rs, rt, imm16}.
  - R-type: {6'b0, rs, rt, rd, 5'b0, funct}.
  - J: {6'b000010, imm26}.
  - Opcodes: LW 100011, SW 101011, ADDI 001000, BEQ 000100.
  - Functs: ADD 100000, SUB 100010, SLT 101010, MUL 011100.
- Field don't-cares are forced to zero: rd for I-type, imm[25:16] for I-type, rs/rt/rd for J.
- start while busy is ignored.
- imem_wdata holds its last value when imem_we=0.
- Reset asserted mid-WRITE drops imem_we immediately (asynchronous), with no partial state retained.

Optional Feature:
- Macro: MIPS_ENC_CHECKSUM_EN.
- Defined:
  - chksum is the XOR of every word written this session, updated in the WRITE cycle.
  - chksum is valid from the DONE cycle.
- Undefined: chksum is tied to 32'h0 and no checksum register is built.

Decomposition:
- Package mips_isa_pkg holds:
  - the opcode and funct localparams above;
  - the in_op enum typedef;
  - the FSM state typedef.
- The mips_isa_pkg constants are shared with the control unit.
- Sub-module mips_word_pack: purely combinational {op, rs, rt, rd, imm} -> {word, illegal}, reused by testbench golden models.

Test Plan:
- LW rs=29 rt=8 imm=0x0004 -> imem_we at addr 0, wdata 0x8FA80004, count=1.
- ADD rd=3 rs=1 rt=2, then MUL rd=4 rs=5 rt=6 (in_last) -> 0x00221820 @0, 0x00A6201C @1, done pulse, count=2.
- BEQ rs=1 rt=2 imm=0xFFFF, then J target 0x0000010 -> 0x1022FFFF @0, 0x08000010 @1; with macro, chksum=0x1822FFEF.
- op=4'hC, then a valid ADDI rt=8 rs=0 imm=5 -> err=1, no write for op C, 0x20080005 written @0.
- ADDR_W=2, 5 words with no in_last -> writes @0..3, err=1 after the 4th, done, in_ready=0, 5th word never accepted.
- rst_n low during a WRITE cycle -> imem_we falls at once; after release, all outputs are 0 and state is IDLE.
